// File: rtl/mem_req_arbiter.sv
// Two-port (fetch/data) arbiter onto a single outstanding-limited memory request bus.
// Keeps an in-order FIFO of {source, drop} tags so responses route back and flushed fetches vanish.
module mem_req_arbiter #(
   parameter int unsigned OUTSTANDING  = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        flush,

   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,

   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,

   output logic        m_req,
   output logic        m_wr,
   output logic [1:0]  m_size,
   output logic [3:0]  m_wstrb,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic        m_addr_ok,
   input  logic        m_data_ok,
   input  logic [31:0] m_rdata
);

   localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
   localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);
   localparam int unsigned STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

   typedef enum logic [1:0] {StIdle, StHoldI, StHoldD} state_e;

   typedef struct packed {
      logic is_data;
      logic drop;
   } ent_t;

   state_e             state_q, state_d;
   logic               wr_q, wr_d;
   logic [1:0]         size_q, size_d;
   logic [3:0]         wstrb_q, wstrb_d;
   logic [31:0]        addr_q, addr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic               hold_drop_q, hold_drop_d;
   logic [STV_W-1:0]   starve_q, starve_d;

   ent_t               ent_q [OUTSTANDING];
   ent_t               ent_d [OUTSTANDING];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               fifo_full;
   logic               fifo_empty;
   logic               inst_go;
   logic               starved;
   logic               hold;
   logic               push;
   logic               push_is_data;
   logic               push_drop;
   logic               pop;
   ent_t               head;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   assign fifo_full  = (cnt_q == CNT_W'(OUTSTANDING));
   assign fifo_empty = (cnt_q == '0);
   assign inst_go    = inst_req & ~flush;
   assign starved    = (starve_q == STV_W'(STARVE_LIMIT));
   assign hold       = (state_q != StIdle);
   assign head       = ent_q[rd_ptr_q];
   assign pop        = m_data_ok & ~fifo_empty;

   // Payload is only presented while a request is being held.
   assign m_req   = hold;
   assign m_wr    = hold & wr_q;
   assign m_size  = hold ? size_q  : '0;
   assign m_wstrb = hold ? wstrb_q : '0;
   assign m_addr  = hold ? addr_q  : '0;
   assign m_wdata = hold ? wdata_q : '0;

   assign inst_data_ok = pop & ~head.is_data & ~head.drop & ~flush;
   assign data_data_ok = pop & head.is_data;
   assign inst_rdata   = inst_data_ok ? m_rdata : '0;
   assign data_rdata   = data_data_ok ? m_rdata : '0;

   always_comb begin
      state_d      = state_q;
      wr_d         = wr_q;
      size_d       = size_q;
      wstrb_d      = wstrb_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      hold_drop_d  = hold_drop_q;
      starve_d     = starve_q;
      push         = 1'b0;
      push_is_data = 1'b0;
      push_drop    = 1'b0;
      inst_addr_ok = 1'b0;
      data_addr_ok = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (!fifo_full && (inst_go || data_req)) begin
               hold_drop_d = 1'b0;
               if (inst_go && (!data_req || starved)) begin
                  state_d  = StHoldI;
                  wr_d     = 1'b0;
                  size_d   = 2'b10;
                  wstrb_d  = '0;
                  addr_d   = inst_addr;
                  wdata_d  = '0;
                  starve_d = '0;
               end else begin
                  state_d = StHoldD;
                  wr_d    = data_wr;
                  size_d  = data_size;
                  wstrb_d = data_wstrb;
                  addr_d  = data_addr;
                  wdata_d = data_wdata;
                  if (inst_req && !starved) starve_d = starve_q + 1'b1;
               end
            end
         end
         StHoldI: begin
            // A flushed fetch still completes its address phase but is tagged for silent discard.
            if (flush) hold_drop_d = 1'b1;
            if (m_addr_ok) begin
               push         = 1'b1;
               push_drop    = hold_drop_q | flush;
               inst_addr_ok = ~(hold_drop_q | flush);
               state_d      = StIdle;
            end
         end
         StHoldD: begin
            if (m_addr_ok) begin
               push         = 1'b1;
               push_is_data = 1'b1;
               data_addr_ok = 1'b1;
               state_d      = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      ent_d    = ent_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;

      if (flush) begin
         for (int i = 0; i < int'(OUTSTANDING); i++) begin
            if (!ent_q[i].is_data) ent_d[i].drop = 1'b1;
         end
      end
      if (push) begin
         ent_d[wr_ptr_q] = '{is_data: push_is_data, drop: push_drop};
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);

      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= StIdle;
         wr_q        <= 1'b0;
         size_q      <= '0;
         wstrb_q     <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         hold_drop_q <= 1'b0;
         starve_q    <= '0;
         ent_q       <= '{default: '0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         wr_q        <= wr_d;
         size_q      <= size_d;
         wstrb_q     <= wstrb_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         hold_drop_q <= hold_drop_d;
         starve_q    <= starve_d;
         ent_q       <= ent_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed table, corner-case sequences, then random traffic
// checked every cycle against a queue-based transaction model.
module tb_mem_req_arbiter;

   localparam int unsigned OUTST = 2;
   localparam int unsigned SLIM  = 4;

   logic        clk = 1'b0;
   logic        rstn, flush;
   logic        inst_req, inst_addr_ok, inst_data_ok;
   logic [31:0] inst_addr, inst_rdata;
   logic        data_req, data_wr, data_addr_ok, data_data_ok;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic        m_req, m_wr, m_addr_ok, m_data_ok;
   logic [1:0]  m_size;
   logic [3:0]  m_wstrb;
   logic [31:0] m_addr, m_wdata, m_rdata;

   always #5 clk = ~clk;

   mem_req_arbiter #(.OUTSTANDING(OUTST), .STARVE_LIMIT(SLIM)) dut (
      .clk(clk), .rstn(rstn), .flush(flush),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
   );

   int n_vec  = 0;
   int n_miss = 0;

   // Transaction model: one held request plus an in-order queue of {is_data, drop} tags.
   bit          pend = 0, pend_data = 0, pend_drop = 0;
   bit          p_wr = 0;
   bit [1:0]    p_size = 0;
   bit [3:0]    p_wstrb = 0;
   bit [31:0]   p_addr = 0, p_wdata = 0;
   int          starve = 0;
   bit [1:0]    mq[$];

   typedef struct {
      logic rs, fl, ir, dr, dw, aok, dok;
      logic [31:0] rd;
      logic e_mreq, e_mwr, e_iaok, e_daok, e_iok, e_dok;
   } vec_t;
   vec_t tab[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic rs, input logic fl, input logic ir, input logic dr,
                         input logic dw, input logic aok, input logic dok,
                         input logic [31:0] rd);
      rstn = rs; flush = fl; inst_req = ir; data_req = dr; data_wr = dw;
      m_addr_ok = aok; m_data_ok = dok; m_rdata = rd;
   endtask

   task automatic settle();
      #4;
   endtask

   // Compare every output with the model, advance the model, then move to the next cycle.
   task automatic finish_cycle();
      bit       pop, iok, inst_g;
      bit [1:0] hd;
      int       sz;
      sz  = mq.size();
      pop = m_data_ok && (sz > 0);
      hd  = pop ? mq[0] : 2'b00;
      iok = pop && !hd[1] && !hd[0] && !flush;
      chk("m_req", m_req, pend);
      chk("m_wr", m_wr, pend ? p_wr : 1'b0);
      chk("m_size", m_size, pend ? p_size : 2'b0);
      chk("m_wstrb", m_wstrb, pend ? p_wstrb : 4'b0);
      chk("m_addr", m_addr, pend ? p_addr : 32'b0);
      chk("m_wdata", m_wdata, pend ? p_wdata : 32'b0);
      chk("inst_addr_ok", inst_addr_ok, pend && !pend_data && m_addr_ok && !pend_drop && !flush);
      chk("data_addr_ok", data_addr_ok, pend && pend_data && m_addr_ok);
      chk("inst_data_ok", inst_data_ok, iok);
      chk("inst_rdata", inst_rdata, iok ? m_rdata : 32'b0);
      chk("data_data_ok", data_data_ok, pop && hd[1]);
      chk("data_rdata", data_rdata, (pop && hd[1]) ? m_rdata : 32'b0);

      if (!rstn) begin
         mq.delete();
         pend = 0; pend_data = 0; pend_drop = 0; starve = 0;
         p_wr = 0; p_size = 0; p_wstrb = 0; p_addr = 0; p_wdata = 0;
      end else begin
         if (pop) void'(mq.pop_front());
         if (flush) foreach (mq[i]) if (!mq[i][1]) mq[i][0] = 1'b1;
         if (pend) begin
            if (flush && !pend_data) pend_drop = 1;
            if (m_addr_ok) begin
               mq.push_back({pend_data, pend_drop});
               pend = 0;
            end
         end else begin
            inst_g = inst_req && !flush;
            if (sz < int'(OUTST) && (inst_g || data_req)) begin
               if (inst_g && (!data_req || starve == int'(SLIM))) begin
                  pend_data = 0; p_wr = 0; p_size = 2; p_wstrb = 0;
                  p_addr = inst_addr; p_wdata = 0; starve = 0;
               end else begin
                  pend_data = 1; p_wr = data_wr; p_size = data_size; p_wstrb = data_wstrb;
                  p_addr = data_addr; p_wdata = data_wdata;
                  if (inst_req && starve < int'(SLIM)) starve++;
               end
               pend = 1; pend_drop = 0;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      settle();
      finish_cycle();
   endtask

   task automatic do_reset();
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
   endtask

   initial begin
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      inst_addr = 32'h1c00_0000; data_addr = 32'h8000_0010; data_size = 2'd2;
      data_wstrb = 4'hf; data_wdata = 32'hcafe_0000;
      @(posedge clk);
      #1;

      //          rs fl ir dr dw aok dok rdata          mreq mwr iaok daok iok dok
      tab[0] = '{0, 0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0};
      tab[1] = '{1, 0, 1, 1, 1, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0};
      tab[2] = '{1, 0, 1, 0, 0, 1, 0, 32'h0,          1, 1, 0, 1, 0, 0};
      tab[3] = '{1, 0, 1, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0};
      tab[4] = '{1, 0, 0, 0, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0};
      tab[5] = '{1, 0, 0, 0, 0, 0, 1, 32'h1111_1111,  0, 0, 0, 0, 0, 1};
      tab[6] = '{1, 0, 0, 0, 0, 0, 1, 32'h2222_2222,  0, 0, 0, 0, 1, 0};
      tab[7] = '{1, 0, 0, 0, 0, 0, 1, 32'h3333_3333,  0, 0, 0, 0, 0, 0};
      for (int k = 0; k < 8; k++) begin
         set_in(tab[k].rs, tab[k].fl, tab[k].ir, tab[k].dr, tab[k].dw, tab[k].aok, tab[k].dok,
                tab[k].rd);
         settle();
         chk($sformatf("tab%0d_m_req", k), m_req, tab[k].e_mreq);
         chk($sformatf("tab%0d_m_wr", k), m_wr, tab[k].e_mwr);
         chk($sformatf("tab%0d_inst_addr_ok", k), inst_addr_ok, tab[k].e_iaok);
         chk($sformatf("tab%0d_data_addr_ok", k), data_addr_ok, tab[k].e_daok);
         chk($sformatf("tab%0d_inst_data_ok", k), inst_data_ok, tab[k].e_iok);
         chk($sformatf("tab%0d_data_data_ok", k), data_data_ok, tab[k].e_dok);
         finish_cycle();
      end

      // Starvation: four data grants, fifth goes to fetch, then data wins again.
      do_reset();
      for (int k = 0; k < 12; k++) begin
         set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h5a5a_0000 + k);
         settle();
         chk($sformatf("starve_iaok_c%0d", k), inst_addr_ok, k == 9);
         chk($sformatf("starve_daok_c%0d", k), data_addr_ok, (k % 2 == 1) && (k != 9));
         finish_cycle();
      end

      // Outstanding limit: two accepted, no m_req while full, one response frees a slot.
      do_reset();
      for (int k = 0; k < 9; k++) begin
         set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, k < 4, k == 6, 32'h7777_0000);
         settle();
         if (k >= 4 && k <= 7) chk($sformatf("full_no_mreq_c%0d", k), m_req, 1'b0);
         if (k == 6) chk("full_pop_data_ok", data_data_ok, 1'b1);
         if (k == 8) chk("full_regrant_mreq", m_req, 1'b1);
         finish_cycle();
      end

      // Accepted fetch flushed before its response; following data response still delivered.
      do_reset();
      set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0); tick();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0); settle();
      chk("flq_inst_addr_ok", inst_addr_ok, 1'b1); finish_cycle();
      set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0); tick();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0); tick();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hdead_beef); settle();
      chk("flq_inst_data_ok", inst_data_ok, 1'b0);
      chk("flq_inst_rdata", inst_rdata, 32'h0); finish_cycle();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678); settle();
      chk("flq_data_rdata", data_rdata, 32'h1234_5678); finish_cycle();

      // Flush while the fetch request is held.
      do_reset();
      set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0); tick();
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0); settle();
      chk("flh_mreq_c1", m_req, 1'b1); finish_cycle();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0); settle();
      chk("flh_mreq_c2", m_req, 1'b1);
      chk("flh_inst_addr_ok", inst_addr_ok, 1'b0); finish_cycle();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4444_4444); settle();
      chk("flh_inst_data_ok", inst_data_ok, 1'b0); finish_cycle();

      // Flush coincident with the fetch response.
      do_reset();
      set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0); tick();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0); tick();
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h9999_9999); settle();
      chk("flr_inst_data_ok", inst_data_ok, 1'b0); finish_cycle();

      // Reset pulse during a held data request.
      do_reset();
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0); tick();
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0); settle();
      chk("rst_hold_mreq", m_req, 1'b1); finish_cycle();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0); settle();
      chk("rst_after_mreq", m_req, 1'b0); finish_cycle();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h6666_6666); settle();
      chk("rst_stray_data_ok", data_data_ok, 1'b0); finish_cycle();

      // Random traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         set_in($urandom_range(0, 149) != 0, $urandom_range(0, 9) == 0, 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
         inst_addr  = $urandom & 32'hffff_fffc;
         data_addr  = $urandom;
         data_size  = 2'($urandom_range(0, 2));
         data_wstrb = 4'($urandom);
         data_wdata = $urandom;
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
